oam_dma: RTL and testbench

- Sprite DMA engine between the cpu_2a03 bus master and the shared memory bus.
- A CPU write to $4014 with value P halts the CPU and copies the 256 bytes at $PP00-$PPFF to the PPU OAM data port ($2004).
- Output bus muxes to the CPU when idle and to the DMA engine when active.
- Memory uses the existing convention: read data for an address presented in cycle N is valid on data_in in cycle N+1.

---
 rtl/oam_dma.sv | 100 ++++++++++
 tb/tb_oam_dma.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write of P to $4014 halts the CPU and copies $PP00-$PPFF to OAMDATA.
// 513/514 halted cycles per transfer; bus passes through from the CPU when idle.
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_rw,
    input  logic [7:0]  data_in,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    output logic        rw,
    output logic        cpu_halt,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic        parity_q, parity_d;

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        parity_d   = ~parity_q;
        addr       = cpu_addr;
        data_out   = cpu_data_out;
        rw         = cpu_rw;
        cpu_halt   = 1'b1;
        dma_active = 1'b1;

        case (state_q)
            IDLE: begin
                cpu_halt   = 1'b0;
                dma_active = 1'b0;
                if (!cpu_rw && cpu_addr == TRIGGER_ADDR) begin
                    page_d  = cpu_data_out;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            HALT: begin
                // Dummy read at the CPU address; reads must fall on parity 0.
                rw      = 1'b1;
                state_d = parity_q ? READ : ALIGN;
            end
            ALIGN: begin
                rw      = 1'b1;
                state_d = READ;
            end
            READ: begin
                addr    = {page_q, idx_q};
                rw      = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                addr     = OAMDATA_ADDR;
                rw       = 1'b0;
                data_out = data_in;
                if (idx_q == 8'hFF) begin
                    idx_d   = 8'h00;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: passthrough vector table plus multi-cycle transfer sequences.
module tb_oam_dma;

    logic        clock;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_rw;
    logic [7:0]  data_in;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        rw;
    logic        cpu_halt;
    logic        dma_active;

    oam_dma dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_rw       (cpu_rw),
        .data_in      (data_in),
        .addr         (addr),
        .data_out     (data_out),
        .rw           (rw),
        .cpu_halt     (cpu_halt),
        .dma_active   (dma_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Edges since the last reset edge; its LSB is the expected DMA parity.
    int cyc = 0;
    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    // Read-only memory with one-cycle read latency.
    logic [7:0]  mem [0:65535];
    logic [15:0] cap_addr;
    always @(posedge clock) data_in <= mem[cap_addr];

    // Bus trace of every halted cycle: {rw, addr, data_out}.
    logic [24:0] tr [0:8191];
    int          tr_n = 0;
    int          hit0800 = 0;
    always @(negedge clock) begin
        cap_addr = addr;
        if (cpu_halt && tr_n < 8192) begin
            tr[tr_n] = {rw, addr, data_out};
            tr_n = tr_n + 1;
        end
        if (dma_active && addr == 16'h0800) hit0800 = hit0800 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_addr     = 16'hC123;
        cpu_data_out = 8'h00;
        cpu_rw       = 1'b1;
    endtask

    // Full transfer of page pg with HALT landing on parity want_par.
    // retrig > 0 holds a $4014 write of $05 on the CPU side for 3 cycles mid-transfer.
    task automatic run_xfer(input string tag, input logic [7:0] pg, input bit want_par,
                            input int retrig);
        int base, n, pre, bad, nwr;
        bit done;
        logic [24:0] e;
        logic [15:0] sa;
        @(posedge clock); #1;
        while (((cyc + 1) % 2) != int'(want_par)) begin
            @(posedge clock); #1;
        end
        cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = pg;
        @(negedge clock);
        chk({tag, "_trig_pass"}, {cpu_halt, rw, data_out, addr},
            {1'b0, 1'b0, pg, 16'h4014});
        @(posedge clock); #1;
        cpu_idle();
        base = tr_n;
        n    = 0;
        done = 0;
        while (!done && n < 600) begin
            @(negedge clock);
            if (!cpu_halt) done = 1;
            else begin
                n++;
                @(posedge clock); #1;
                if (retrig > 0 && n == retrig) begin
                    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = 8'h05;
                end
                if (retrig > 0 && n == retrig + 3) cpu_idle();
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_halt_len"}, n, want_par ? 513 : 514);
        chk({tag, "_release"}, {dma_active, rw, addr}, {1'b0, 1'b1, 16'hC123});
        pre = want_par ? 1 : 2;
        bad = 0;
        nwr = 0;
        for (int k = base; k < tr_n; k++) if (!tr[k][24]) nwr++;
        for (int k = 0; k < pre; k++) begin
            e = tr[base + k];
            if (e[24] !== 1'b1 || e[23:8] !== 16'hC123) bad++;
        end
        for (int i = 0; i < 256; i++) begin
            sa = {pg, 8'(i)};
            e  = tr[base + pre + 2 * i];
            if (e[24] !== 1'b1 || e[23:8] !== sa) bad++;
            e  = tr[base + pre + 2 * i + 1];
            if (e[24] !== 1'b0 || e[23:8] !== 16'h2004 || e[7:0] !== mem[sa]) bad++;
        end
        chk({tag, "_nwrites"}, nwr, 256);
        chk({tag, "_seq_bad"}, bad, 0);
        sa = {pg, 8'hFF};
        chk({tag, "_last_wr"}, tr[tr_n - 1], {1'b0, 16'h2004, mem[sa]});
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        r;
        logic [15:0] exp_addr;
        logic [7:0]  exp_dat;
        logic        exp_rw;
        logic        exp_halt;
    } vec_t;

    vec_t vecs [0:7];

    initial begin
        int w, base, nwr, h0;
        vecs[0] = '{16'h0300, 8'h5A, 1'b0, 16'h0300, 8'h5A, 1'b0, 1'b0};
        vecs[1] = '{16'h0300, 8'h00, 1'b1, 16'h0300, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{16'h4016, 8'h01, 1'b0, 16'h4016, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{16'h4017, 8'h00, 1'b0, 16'h4017, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{16'h4015, 8'hFF, 1'b0, 16'h4015, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{16'h4014, 8'h02, 1'b1, 16'h4014, 8'h02, 1'b1, 1'b0};
        vecs[6] = '{16'h0014, 8'h02, 1'b0, 16'h0014, 8'h02, 1'b0, 1'b0};
        vecs[7] = '{16'hC123, 8'h00, 1'b1, 16'hC123, 8'h00, 1'b1, 1'b0};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
            mem[16'h0300 + i] = ~8'(i);
            mem[16'h0700 + i] = 8'(i * 7 + 3);
            mem[16'h2000 + i] = 8'(i + 7);
        end
        mem[16'h07FF] = 8'hC3;
        mem[16'h0800] = 8'hEE;

        reset = 1'b1;
        cpu_idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_state", {cpu_halt, dma_active, rw, addr}, {1'b0, 1'b0, 1'b1, 16'hC123});
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cpu_addr = vecs[i].a; cpu_data_out = vecs[i].d; cpu_rw = vecs[i].r;
            @(negedge clock);
            chk($sformatf("pass_vec%0d", i), {cpu_halt, dma_active, rw, data_out, addr},
                {vecs[i].exp_halt, 1'b0, vecs[i].exp_rw, vecs[i].exp_dat, vecs[i].exp_addr});
            @(posedge clock); #1;
        end

        run_xfer("odd_p02", 8'h02, 1'b1, 0);
        run_xfer("even_p02", 8'h02, 1'b0, 0);
        h0 = hit0800;
        run_xfer("last_p07", 8'h07, 1'b1, 0);
        chk("no_0800", hit0800 - h0, 0);
        run_xfer("retrig_p03", 8'h03, 1'b0, 50);
        run_xfer("page_p20", 8'h20, 1'b1, 0);

        // Reset after 100 bytes have been written.
        @(posedge clock); #1;
        cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = 8'h02;
        @(posedge clock); #1;
        cpu_idle();
        base = tr_n;
        w = 0;
        for (int n = 0; n < 600 && w < 100; n++) begin
            @(negedge clock);
            if (cpu_halt && !rw) w++;
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(negedge clock);
        chk("rst_cycle_halted", 32'(cpu_halt), 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_release", {cpu_halt, dma_active, rw, addr}, {1'b0, 1'b0, 1'b1, 16'hC123});
        nwr = 0;
        for (int k = base; k < tr_n; k++) if (!tr[k][24]) nwr++;
        chk("rst_nwrites", nwr, 100);
        run_xfer("after_rst_p02", 8'h02, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
